fht_input_loader: RTL and testbench
===================================

// Module: fht_input_loader
// PURPOSE
//  Upstream stage of the FHT core. Accepts a stream of N = 4*2^A_BIT samples over a
//  valid/ready handshake and writes each into the four working RAM banks at its
//  bit-reversed position. After the last write it pulses oSTART to the FHT controller.
//  It then holds off the next frame until the controller reports ready again.
// PARAMETERS
//  A_BIT   8   bank address width; N = 4*2^A_BIT points (default 1024)
//  D_BIT   16  sample width
// PORTS
//  iCLK        in   1      single clock; all logic on posedge
//  iRESET      in   1      synchronous, active-low reset
//  iDATA       in   D_BIT  input sample
//  iVALID      in   1      iDATA valid
//  oREADY      out  1      loader accepts a sample this cycle
//  iFHT_RDY    in   1      FHT controller idle (its ready flag)
//  oADDR_WR    out  A_BIT  bank write address, shared by all banks
//  oDATA_WR    out  D_BIT  bank write data, shared by all banks
//  oWE_0..3    out  1 each one-hot bank write enables
//  oSTART      out  1      one-cycle start pulse to FHT controller
//  oBUSY       out  1      frame loaded or transform running (not LOAD/IDLE)
// BEHAVIOUR
//  Reset (iRESET==0 at posedge): state=IDLE, idx=0. All outputs 0, incl. oREADY and oWE_*.
//  Index: idx is an (A_BIT+2)-bit counter of accepted samples. rev = bit-reverse(idx).
//   Bank = rev[1:0]; address = rev[A_BIT+1:2].
//  Write: accept = iVALID & oREADY. On the next cycle, the registered outputs present
//   the write: oDATA_WR=iDATA, oADDR_WR=addr, oWE_<bank>=1, other oWE_*=0.
//   Write latency is exactly 1 cycle. oWE_* are 0 in every non-write cycle.
//  FSM:
//   IDLE      oREADY=0. Go to LOAD when iFHT_RDY==1.
//   LOAD      oREADY=1. Each accept increments idx. The accept at idx==N-1 wraps idx
//             to 0, drops oREADY the next cycle and goes to START.
//   START     Entered the cycle the last write is on the bank ports. oSTART=1 for
//             exactly 1 cycle. Go to WAIT_ACK.
//   WAIT_ACK  Wait for iFHT_RDY==0 (controller has taken the start), then go to
//             WAIT_DONE. If iFHT_RDY is still 1 after 4 cycles, reissue oSTART
//             (go to START).
//   WAIT_DONE Go to LOAD when iFHT_RDY==1.
//  oBUSY = state in {START, WAIT_ACK, WAIT_DONE}.
//  Boundaries:
//   - iVALID low in LOAD: idx holds and no write is issued. Gaps are allowed anywhere
//     in the frame.
//   - iVALID is ignored outside LOAD. No sample is dropped, because oREADY=0 there.
//   - Reset mid-frame: partial frame discarded, idx=0, no oSTART issued.
//   - iFHT_RDY falling during LOAD (foreign start): ignored. The loader still completes
//     its frame.
// CONFIGURATION
//  FHT_LOADER_BITREV_EN defined: addressing as above (bit-reversed).
//  Not defined: rev = idx (natural order), bank = idx[1:0], address = idx[A_BIT+1:2].
//   Used when the upstream source already delivers bit-reversed data.
//   FSM and timing are identical in both builds.
// STRUCTURE
//  Shared package fht_pkg: FSM state enum (IDLE, LOAD, START, WAIT_ACK, WAIT_DONE),
//  N_BANK=4, start-retry limit (4), and a bitrev function parameterised by width.
//  One sub-module: fht_bitrev_addr, a combinational idx -> {bank, addr} mapper that
//  contains the FHT_LOADER_BITREV_EN switch. FSM, counter and output registers stay
//  in the top module.
// TESTING
//  1 Reset: hold iRESET=0 for 3 cycles -> all outputs 0. Release with iFHT_RDY=1
//    -> oREADY=1 two cycles later (IDLE->LOAD).
//  2 Bitrev map (BITREV_EN): samples idx 0,1,2,512,1023 ->
//    (bank,addr) = (0,0x00), (0,0x80), (0,0x40), (1,0x00), (3,0xFF), each with
//    oDATA_WR equal to the sample and exactly one oWE_*.
//  3 Full frame with random iVALID gaps (50%): 1024 writes, each address used exactly
//    once per bank. oSTART=1 for 1 cycle, exactly 1 cycle after the last oWE_*.
//  4 Handshake hold: iFHT_RDY drops 2 cycles after oSTART and rises 500 cycles later.
//    oREADY=0 and oBUSY=1 throughout. oREADY=1 one cycle after the rise.
//  5 Start retry: iFHT_RDY stays 1 after oSTART -> second oSTART pulse 5 cycles later,
//    with no extra writes.
//  6 Reset at idx=300 -> no oSTART. The next frame starts at idx 0 (first write goes
//    to bank 0, addr 0). Without BITREV_EN, idx 5 -> bank 1, addr 0x01.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared FHT types and constants: loader FSM states, bank count, start-retry limit, bit reversal.
// Latency: none (package only).
// Backpressure: not applicable.
package fht_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_ACK,
        WAIT_DONE
    } fht_state_t;

    localparam int N_BANK      = 4;
    localparam int START_RETRY = 4;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_bitrev_addr.sv
// Maps a sample index to {bank, address}; bit-reversed when FHT_LOADER_BITREV_EN is defined, natural order otherwise.
// Latency: combinational.
// Backpressure: not applicable.
module fht_bitrev_addr
    import fht_pkg::*;
#(
    parameter int A_BIT = 8
) (
    input  logic [A_BIT+1:0] idx,
    output logic [1:0]       bank,
    output logic [A_BIT-1:0] addr
);

    localparam int IDX_W = A_BIT + 2;

    logic [IDX_W-1:0] rev;

`ifdef FHT_LOADER_BITREV_EN
    assign rev = IDX_W'(bitrev(32'(idx), IDX_W));
`else
    assign rev = idx;
`endif

    assign bank = rev[1:0];
    assign addr = rev[IDX_W-1:2];

endmodule

// File: rtl/fht_input_loader.sv
// Loads one N-point frame into the four FHT banks at its mapped position, then pulses oSTART to the controller (FHT_LOADER_BITREV_EN selects bit-reversed addressing).
// Latency: a bank write appears 1 cycle after its accept; oSTART follows the last write by 1 cycle.
// Backpressure: oREADY is high only while loading; it stays low until the controller is ready again.
module fht_input_loader
    import fht_pkg::*;
#(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic             iFHT_RDY,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [D_BIT-1:0] oDATA_WR,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    output logic             oSTART,
    output logic             oBUSY
);

    localparam int IDX_W   = A_BIT + 2;
    localparam int RETRY_W = $clog2(START_RETRY);

    fht_state_t          state;
    logic [IDX_W-1:0]    idx;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [N_BANK-1:0]   we;
    logic [1:0]          map_bank;
    logic [A_BIT-1:0]    map_addr;
    logic                accept;

    assign accept = iVALID & oREADY;

    fht_bitrev_addr #(
        .A_BIT (A_BIT)
    ) u_map (
        .idx  (idx),
        .bank (map_bank),
        .addr (map_addr)
    );

    assign oWE_0 = we[0];
    assign oWE_1 = we[1];
    assign oWE_2 = we[2];
    assign oWE_3 = we[3];

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state     <= IDLE;
            idx       <= '0;
            retry_cnt <= '0;
            oREADY    <= 1'b0;
            oBUSY     <= 1'b0;
            oSTART    <= 1'b0;
            oADDR_WR  <= '0;
            oDATA_WR  <= '0;
            we        <= '0;
        end else begin
            oSTART <= 1'b0;
            we     <= '0;
            if (accept) begin
                oDATA_WR <= iDATA;
                oADDR_WR <= map_addr;
                we       <= N_BANK'(1) << map_bank;
                idx      <= idx + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (iFHT_RDY) begin
                        state  <= LOAD;
                        oREADY <= 1'b1;
                    end
                end
                LOAD: begin
                    // The final accept puts the last write on the ports as START begins.
                    if (accept && (idx == '1)) begin
                        state  <= START;
                        oREADY <= 1'b0;
                        oBUSY  <= 1'b1;
                    end
                end
                START: begin
                    oSTART    <= 1'b1;
                    retry_cnt <= '0;
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!iFHT_RDY) begin
                        state <= WAIT_DONE;
                    end else if (retry_cnt == RETRY_W'(START_RETRY - 1)) begin
                        state <= START;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (iFHT_RDY) begin
                        state  <= LOAD;
                        oREADY <= 1'b1;
                        oBUSY  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    oREADY <= 1'b0;
                    oBUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fht_input_loader.sv
// Randomized bench for fht_input_loader against a cycle-level reference model of the loader protocol.
module tb_fht_input_loader;

    localparam int A_BIT = 8;
    localparam int D_BIT = 16;
    localparam int N     = 4 * (1 << A_BIT);

    logic             iCLK = 1'b0;
    logic             iRESET = 1'b0;
    logic [D_BIT-1:0] iDATA = '0;
    logic             iVALID = 1'b0;
    logic             iFHT_RDY = 1'b0;
    logic             oREADY;
    logic [A_BIT-1:0] oADDR_WR;
    logic [D_BIT-1:0] oDATA_WR;
    logic             oWE_0, oWE_1, oWE_2, oWE_3;
    logic             oSTART;
    logic             oBUSY;

    always #5 iCLK = ~iCLK;

    fht_input_loader #(
        .A_BIT (A_BIT),
        .D_BIT (D_BIT)
    ) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iDATA    (iDATA),
        .iVALID   (iVALID),
        .oREADY   (oREADY),
        .iFHT_RDY (iFHT_RDY),
        .oADDR_WR (oADDR_WR),
        .oDATA_WR (oDATA_WR),
        .oWE_0    (oWE_0),
        .oWE_1    (oWE_1),
        .oWE_2    (oWE_2),
        .oWE_3    (oWE_3),
        .oSTART   (oSTART),
        .oBUSY    (oBUSY)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: protocol phases, accepted-sample count, expected outputs.
    localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_ACK = 3, P_DONE = 4;
    int         m_phase = P_IDLE;
    int         m_count = 0;
    int         m_ack   = 0;
    bit         e_ready = 0, e_busy = 0, e_start = 0;
    logic [3:0] e_we = '0;
    int         e_addr = 0, e_data = 0;

    task automatic map_idx(input int idx, output int bank, output int addr);
        int rev;
        rev = 0;
`ifdef FHT_LOADER_BITREV_EN
        for (int b = 0; b < A_BIT + 2; b++) rev = rev * 2 + ((idx >> b) & 1);
`else
        rev = idx;
`endif
        bank = rev % 4;
        addr = rev / 4;
    endtask

    task automatic model_update(input bit rst, input bit v, input int d, input bit r);
        bit acc;
        int b, a;
        if (!rst) begin
            m_phase = P_IDLE; m_count = 0; m_ack = 0;
            e_ready = 0; e_busy = 0; e_start = 0; e_we = '0;
            return;
        end
        acc     = v && e_ready;
        e_we    = '0;
        e_start = 0;
        if (acc) begin
            map_idx(m_count, b, a);
            e_we[b] = 1'b1;
            e_addr  = a;
            e_data  = d;
            m_count = (m_count + 1) % N;
        end
        case (m_phase)
            P_IDLE:  if (r) m_phase = P_LOAD;
            P_LOAD:  if (acc && m_count == 0) m_phase = P_START;
            P_START: begin e_start = 1; m_ack = 0; m_phase = P_ACK; end
            P_ACK: begin
                if (!r) m_phase = P_DONE;
                else begin
                    m_ack++;
                    if (m_ack == 4) m_phase = P_START;
                end
            end
            default: if (r) m_phase = P_LOAD;
        endcase
        e_ready = (m_phase == P_LOAD);
        e_busy  = (m_phase >= P_START);
    endtask

    // Observation of DUT writes and start pulses.
    int cyc = 0, w_cnt = 0, n_start = 0, last_we_cyc = 0, start_cyc = 0;
    int obs_bank[N];
    int obs_addr[N];
    bit used[N];

    task automatic clear_frame;
        w_cnt = 0;
        for (int i = 0; i < N; i++) used[i] = 0;
    endtask

    task automatic observe;
        int b, slot;
        if ({oWE_3, oWE_2, oWE_1, oWE_0} != 4'b0000) begin
            b = oWE_0 ? 0 : oWE_1 ? 1 : oWE_2 ? 2 : 3;
            slot = b * (1 << A_BIT) + int'(oADDR_WR);
            if (w_cnt < N) begin
                obs_bank[w_cnt] = b;
                obs_addr[w_cnt] = int'(oADDR_WR);
            end
            check("addr_unique", 32'(used[slot]), 0);
            used[slot] = 1;
            w_cnt++;
            last_we_cyc = cyc;
        end
        if (oSTART) begin
            n_start++;
            start_cyc = cyc;
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit r);
        logic [D_BIT-1:0] d;
        d = D_BIT'($urandom);
        iRESET = rst; iVALID = v; iFHT_RDY = r; iDATA = d;
        @(posedge iCLK);
        cyc++;
        model_update(rst, v, int'(d), r);
        #1;
        check("ready", 32'(oREADY), 32'(e_ready));
        check("busy",  32'(oBUSY),  32'(e_busy));
        check("start", 32'(oSTART), 32'(e_start));
        check("we", 32'({oWE_3, oWE_2, oWE_1, oWE_0}), 32'(e_we));
        if (e_we != 4'b0000) begin
            check("addr", 32'(oADDR_WR), e_addr);
            check("data", 32'(oDATA_WR), e_data);
        end
        observe();
    endtask

    task automatic run_frame(input bit rand_rdy, output bit timed_out);
        int s0, it;
        bit r;
        s0 = n_start; it = 0; timed_out = 0;
        while (n_start == s0) begin
            r = (rand_rdy && w_cnt < 1000) ? bit'($urandom_range(1)) : 1'b1;
            step(1, bit'($urandom_range(1)), r);
            it++;
            if (it > 6000) begin timed_out = 1; break; end
        end
    endtask

    task automatic frame_checks;
        int used_cnt;
        used_cnt = 0;
        for (int i = 0; i < N; i++) used_cnt += int'(used[i]);
        check("frame_writes", w_cnt, N);
        check("all_addr_once", used_cnt, N);
        check("start_after_last_we", start_cyc - last_we_cyc, 1);
    endtask

    int pin_idx[5] = '{0, 1, 2, 512, 1023};
`ifdef FHT_LOADER_BITREV_EN
    int pin_bank[5] = '{0, 0, 0, 1, 3};
    int pin_addr[5] = '{8'h00, 8'h80, 8'h40, 8'h00, 8'hFF};
    int idx5_bank = 0, idx5_addr = 8'hA0;
`else
    int pin_bank[5] = '{0, 1, 2, 0, 3};
    int pin_addr[5] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'hFF};
    int idx5_bank = 1, idx5_addr = 8'h01;
`endif

    initial begin
        bit to;
        int w_save, s_save, it;

        // Reset held, then release with the controller ready.
        repeat (3) step(0, 1, 1);
        check("rst_ready", 32'(oREADY), 0);
        check("rst_busy",  32'(oBUSY), 0);
        check("rst_start", 32'(oSTART), 0);
        check("rst_we", 32'({oWE_3, oWE_2, oWE_1, oWE_0}), 0);
        check("rst_addr", 32'(oADDR_WR), 0);
        step(1, 0, 1);
        step(1, 0, 1);
        check("ready_after_release", 32'(oREADY), 1);

        // Frame 1: random gaps, mapping pins.
        clear_frame();
        run_frame(0, to);
        check("frame1_timeout", 32'(to), 0);
        frame_checks();
        for (int k = 0; k < 5; k++) begin
            check("pin_bank", obs_bank[pin_idx[k]], pin_bank[k]);
            check("pin_addr", obs_addr[pin_idx[k]], pin_addr[k]);
        end

        // Controller acks 2 cycles after oSTART, busy for 500 cycles.
        step(1, bit'($urandom_range(1)), 1);
        for (int i = 0; i < 500; i++) begin
            step(1, bit'($urandom_range(1)), 0);
            check("hold_ready", 32'(oREADY), 0);
            check("hold_busy",  32'(oBUSY), 1);
        end
        step(1, 0, 1);
        check("ready_after_rise", 32'(oREADY), 1);
        check("busy_after_rise",  32'(oBUSY), 0);

        // Frame 2: foreign iFHT_RDY toggling during load, then start retry.
        clear_frame();
        run_frame(1, to);
        check("frame2_timeout", 32'(to), 0);
        frame_checks();
        w_save = w_cnt;
        s_save = n_start;
        for (int i = 1; i <= 5; i++) begin
            step(1, bit'($urandom_range(1)), 1);
            check("retry_start", 32'(oSTART), 32'(i == 5));
        end
        check("retry_no_write", w_cnt, w_save);
        check("retry_count", n_start, s_save + 1);
        repeat (3) step(1, bit'($urandom_range(1)), 0);
        step(1, 0, 1);
        check("ready_after_retry", 32'(oREADY), 1);

        // Frame 3: reset at ~300 samples, then restart from index 0.
        clear_frame();
        it = 0;
        while (w_cnt < 300 && it < 1000) begin step(1, 1, 1); it++; end
        check("partial_writes", w_cnt, 300);
        s_save = n_start;
        step(0, 1, 1);
        step(0, 1, 1);
        clear_frame();
        it = 0;
        while (w_cnt < 6 && it < 20) begin step(1, 1, 1); it++; end
        check("restart_writes", w_cnt, 6);
        check("restart_bank0", obs_bank[0], 0);
        check("restart_addr0", obs_addr[0], 0);
        check("restart_bank5", obs_bank[5], idx5_bank);
        check("restart_addr5", obs_addr[5], idx5_addr);
        repeat (4) step(1, 0, 1);
        check("no_start_after_reset", n_start, s_save);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
